accelerator_state_matrix_feeder: RTL and testbench
==================================================

ACCELERATOR_STATE_MATRIX_FEEDER -- requirements
Module: accelerator_state_matrix_feeder

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, setting the width of the data, size and index buses.
REQ-002 SHALL have parameter CONTROL_SIZE, default 4, reserved for control width parity with the state accelerator (unused internally).
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1, reset; it is asynchronous and active-low.
REQ-005 SHALL have port START, input, 1, one-cycle request to begin streaming one matrix.
REQ-006 SHALL have port READY, output, 1, one-cycle pulse marking matrix completion.
REQ-007 SHALL have ports SIZE_I_IN and SIZE_J_IN, input, DATA_SIZE each, the row and column counts.
REQ-008 SHALL have port DATA_IN, input, DATA_SIZE, the upstream element.
REQ-009 SHALL have port DATA_IN_VALID, input, 1, upstream element valid.
REQ-010 SHALL have port DATA_IN_READY, output, 1, feeder accepts an element.
REQ-011 SHALL have port DATA_OUT, output, DATA_SIZE, the element for the state accelerator (DATA_A_IN..DATA_D_IN).
REQ-012 SHALL have ports DATA_OUT_I_ENABLE and DATA_OUT_J_ENABLE, output, 1 each, row-start and element strobes (to DATA_x_IN_I_ENABLE / DATA_x_IN_J_ENABLE).
REQ-013 SHALL have ports INDEX_I_OUT and INDEX_J_OUT, output, DATA_SIZE each, the (i,j) of the element on DATA_OUT.

Function
REQ-014 SHALL implement FSM states IDLE and STREAM; reset state IDLE.
REQ-015 In IDLE with START=1 and both sizes nonzero: latch SIZE_I_IN/SIZE_J_IN, clear counters i=j=0, go to STREAM.
REQ-016 In IDLE with START=1 and either size zero: stay IDLE, pulse READY the next cycle, emit no elements.
REQ-017 START in STREAM SHALL be ignored; latched sizes SHALL not change mid-matrix.
REQ-018 DATA_IN_READY SHALL be 1 exactly while in STREAM; a transfer occurs on a cycle with DATA_IN_VALID=1 and DATA_IN_READY=1.
REQ-019 On a transfer, the next cycle SHALL show DATA_OUT=the element, INDEX_I_OUT/INDEX_J_OUT=its (i,j), DATA_OUT_J_ENABLE=1 (latency one cycle).
REQ-020 DATA_OUT_I_ENABLE SHALL be 1 together with DATA_OUT_J_ENABLE only for elements with j=0.
REQ-021 Ordering SHALL be row-major: j increments per transfer, wraps to 0 at SIZE_J-1 with i incrementing.
REQ-022 On transfer of (SIZE_I-1,SIZE_J-1) FSM SHALL return to IDLE; READY SHALL pulse in the same cycle as that element's J_ENABLE.
REQ-023 Cycles with DATA_IN_VALID=0 in STREAM SHALL produce no strobes and leave counters unchanged; strobes are one cycle wide.
REQ-024 DATA_OUT and INDEX outputs SHALL hold their last value when no strobe is asserted.
REQ-025 START in the cycle READY pulses (FSM in IDLE) SHALL be honoured per REQ-015/016.

Reset
REQ-026 RST low SHALL immediately force IDLE, READY=0, DATA_IN_READY=0, both strobes 0, DATA_OUT=0, INDEX outputs 0, counters and latched sizes 0.
REQ-027 Reset mid-STREAM SHALL abandon the matrix with no READY pulse; after release a new START is required.

Configuration
REQ-028 Macro ACCELERATOR_STATE_FEEDER_COUNT_EN: when defined, SHALL add output ELEMENT_COUNT_OUT (DATA_SIZE), cleared on reset and on accepted START, incremented per transfer, holding the final total after READY.
REQ-029 Without ACCELERATOR_STATE_FEEDER_COUNT_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Sizes 2x3, VALID held 1, data 10..15 -> J_ENABLE six consecutive cycles, I_ENABLE with 10 and 13, indices (0,0)..(1,2), READY with 15.
REQ-031 Sizes 2x2, VALID toggling 1,0,1,0... -> four strobes on alternate cycles, counters frozen during gaps, READY with fourth element.
REQ-032 SIZE_I=0, SIZE_J=5, START -> no strobes, DATA_IN_READY stays 0, READY one cycle after START.
REQ-033 Sizes 3x3, RST low after 4 transfers -> all outputs 0 at once, no READY; new START 1x1 with data 7 -> single element 7 at (0,0), I/J_ENABLE and READY together.
REQ-034 Sizes 1x4, START re-pulsed with 9x9 mid-stream -> ignored; exactly 4 elements then READY.
REQ-035 With ACCELERATOR_STATE_FEEDER_COUNT_EN, sizes 3x2 -> ELEMENT_COUNT_OUT steps 1..6 and holds 6 after READY.

Source files
------------

// File: rtl/accelerator_state_matrix_feeder_if.sv
// Handshake and data bus between the upstream source, the matrix feeder and the state accelerator.
// ELEMENT_COUNT_OUT exists only when ACCELERATOR_STATE_FEEDER_COUNT_EN is defined.
interface accelerator_state_matrix_feeder_if #(
  parameter int DATA_SIZE = 64
);
  logic                 START;
  logic                 READY;
  logic [DATA_SIZE-1:0] SIZE_I_IN;
  logic [DATA_SIZE-1:0] SIZE_J_IN;
  logic [DATA_SIZE-1:0] DATA_IN;
  logic                 DATA_IN_VALID;
  logic                 DATA_IN_READY;
  logic [DATA_SIZE-1:0] DATA_OUT;
  logic                 DATA_OUT_I_ENABLE;
  logic                 DATA_OUT_J_ENABLE;
  logic [DATA_SIZE-1:0] INDEX_I_OUT;
  logic [DATA_SIZE-1:0] INDEX_J_OUT;
`ifdef ACCELERATOR_STATE_FEEDER_COUNT_EN
  logic [DATA_SIZE-1:0] ELEMENT_COUNT_OUT;

  modport master (
    output START, SIZE_I_IN, SIZE_J_IN, DATA_IN, DATA_IN_VALID,
    input  READY, DATA_IN_READY, DATA_OUT, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE,
           INDEX_I_OUT, INDEX_J_OUT, ELEMENT_COUNT_OUT
  );
  modport slave (
    input  START, SIZE_I_IN, SIZE_J_IN, DATA_IN, DATA_IN_VALID,
    output READY, DATA_IN_READY, DATA_OUT, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE,
           INDEX_I_OUT, INDEX_J_OUT, ELEMENT_COUNT_OUT
  );
`else
  modport master (
    output START, SIZE_I_IN, SIZE_J_IN, DATA_IN, DATA_IN_VALID,
    input  READY, DATA_IN_READY, DATA_OUT, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE,
           INDEX_I_OUT, INDEX_J_OUT
  );
  modport slave (
    input  START, SIZE_I_IN, SIZE_J_IN, DATA_IN, DATA_IN_VALID,
    output READY, DATA_IN_READY, DATA_OUT, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE,
           INDEX_I_OUT, INDEX_J_OUT
  );
`endif
endinterface

// File: rtl/accelerator_state_matrix_feeder.sv
// Streams one SIZE_I x SIZE_J matrix, row-major, from a valid/ready source into the state accelerator.
// Optional element counter output enabled by ACCELERATOR_STATE_FEEDER_COUNT_EN.
module accelerator_state_matrix_feeder #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input logic CLK,
  input logic RST,
  accelerator_state_matrix_feeder_if.slave bus
);

  // Reserved for width parity with the state accelerator; only sanity-checked here.
  if (CONTROL_SIZE < 1) begin : g_control_size_check
    $error("CONTROL_SIZE must be at least 1");
  end

  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t               state, state_nxt;
  logic [DATA_SIZE-1:0] size_i, size_j;
  logic [DATA_SIZE-1:0] cnt_i, cnt_j;
  logic                 start_ok, transfer, last_col, last_row, last;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    start_ok  = bus.START && (bus.SIZE_I_IN != '0) && (bus.SIZE_J_IN != '0);
    transfer  = (state == STREAM) && bus.DATA_IN_VALID;
    last_col  = (cnt_j == size_j - ONE);
    last_row  = (cnt_i == size_i - ONE);
    last      = transfer && last_col && last_row;
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = STREAM;
      STREAM:  if (last)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.DATA_IN_READY = (state == STREAM);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: everything here is a small register, so all of it is cleared by the async reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      size_i                <= '0;
      size_j                <= '0;
      cnt_i                 <= '0;
      cnt_j                 <= '0;
      bus.READY             <= 1'b0;
      bus.DATA_OUT          <= '0;
      bus.DATA_OUT_I_ENABLE <= 1'b0;
      bus.DATA_OUT_J_ENABLE <= 1'b0;
      bus.INDEX_I_OUT       <= '0;
      bus.INDEX_J_OUT       <= '0;
`ifdef ACCELERATOR_STATE_FEEDER_COUNT_EN
      bus.ELEMENT_COUNT_OUT <= '0;
`endif
    end else begin
      bus.READY             <= 1'b0;
      bus.DATA_OUT_I_ENABLE <= 1'b0;
      bus.DATA_OUT_J_ENABLE <= 1'b0;

      // A zero-sized request completes immediately without entering STREAM.
      if (state == IDLE && bus.START) begin
        if (start_ok) begin
          size_i <= bus.SIZE_I_IN;
          size_j <= bus.SIZE_J_IN;
          cnt_i  <= '0;
          cnt_j  <= '0;
`ifdef ACCELERATOR_STATE_FEEDER_COUNT_EN
          bus.ELEMENT_COUNT_OUT <= '0;
`endif
        end else begin
          bus.READY <= 1'b1;
        end
      end

      if (transfer) begin
        bus.DATA_OUT          <= bus.DATA_IN;
        bus.INDEX_I_OUT       <= cnt_i;
        bus.INDEX_J_OUT       <= cnt_j;
        bus.DATA_OUT_J_ENABLE <= 1'b1;
        bus.DATA_OUT_I_ENABLE <= (cnt_j == '0);
        bus.READY             <= last;
`ifdef ACCELERATOR_STATE_FEEDER_COUNT_EN
        bus.ELEMENT_COUNT_OUT <= bus.ELEMENT_COUNT_OUT + ONE;
`endif
        if (last_col) begin
          cnt_j <= '0;
          cnt_i <= cnt_i + ONE;
        end else begin
          cnt_j <= cnt_j + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_accelerator_state_matrix_feeder.sv
// Self-checking bench: a linear-index matrix model is compared against the feeder every falling edge.
module tb_accelerator_state_matrix_feeder;

  localparam int W = 64;

  logic CLK;
  logic RST;

  accelerator_state_matrix_feeder_if #(.DATA_SIZE(W)) bus ();

  accelerator_state_matrix_feeder #(.DATA_SIZE(W), .CONTROL_SIZE(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the matrix is a flat sequence of elements k = 0 .. SI*SJ-1, with (i,j) = (k / SJ, k % SJ).
  bit           m_active;
  logic [W-1:0] m_si, m_sj, m_k, m_cnt;
  logic [W-1:0] m_data, m_ii, m_jj;
  bit           m_jen, m_ien, m_rdy;

  task automatic model_reset();
    m_active = 0; m_si = 0; m_sj = 0; m_k = 0; m_cnt = 0;
    m_data = 0; m_ii = 0; m_jj = 0; m_jen = 0; m_ien = 0; m_rdy = 0;
  endtask

  task automatic model_step();
    m_jen = 0; m_ien = 0; m_rdy = 0;
    if (!m_active) begin
      if (bus.START) begin
        if (bus.SIZE_I_IN != 0 && bus.SIZE_J_IN != 0) begin
          m_active = 1; m_si = bus.SIZE_I_IN; m_sj = bus.SIZE_J_IN; m_k = 0; m_cnt = 0;
        end else begin
          m_rdy = 1;
        end
      end
    end else if (bus.DATA_IN_VALID) begin
      m_data = bus.DATA_IN;
      m_ii   = m_k / m_sj;
      m_jj   = m_k % m_sj;
      m_jen  = 1;
      m_ien  = (m_jj == 0);
      m_k    = m_k + 1;
      m_cnt  = m_cnt + 1;
      if (m_k == m_si * m_sj) begin
        m_active = 0;
        m_rdy    = 1;
      end
    end
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) model_reset();
    else      model_step();
  end

  typedef struct {
    logic [W-1:0] d, i, j;
    bit           ien, rdy;
    int           cyc;
  } ev_t;

  ev_t log_q[$];
  int  rdy_cnt;
  int  cyc_n = 0;

  always @(posedge CLK) cyc_n++;

  always @(negedge CLK) begin
    check("data_in_ready", W'(bus.DATA_IN_READY), W'(m_active));
    check("ready",         W'(bus.READY),         W'(m_rdy));
    check("j_enable",      W'(bus.DATA_OUT_J_ENABLE), W'(m_jen));
    check("i_enable",      W'(bus.DATA_OUT_I_ENABLE), W'(m_ien));
    check("data_out",      bus.DATA_OUT,    m_data);
    check("index_i",       bus.INDEX_I_OUT, m_ii);
    check("index_j",       bus.INDEX_J_OUT, m_jj);
`ifdef ACCELERATOR_STATE_FEEDER_COUNT_EN
    check("element_count", bus.ELEMENT_COUNT_OUT, m_cnt);
`endif
    if (bus.DATA_OUT_J_ENABLE)
      log_q.push_back('{d: bus.DATA_OUT, i: bus.INDEX_I_OUT, j: bus.INDEX_J_OUT,
                        ien: bus.DATA_OUT_I_ENABLE, rdy: bus.READY, cyc: cyc_n});
    if (bus.READY) rdy_cnt++;
  end

  task automatic clear_log();
    log_q.delete();
    rdy_cnt = 0;
  endtask

  task automatic pulse_start(input logic [W-1:0] si, input logic [W-1:0] sj, input int n_cyc);
    @(negedge CLK); #1;
    bus.START = 1'b1; bus.SIZE_I_IN = si; bus.SIZE_J_IN = sj;
    repeat (n_cyc) @(negedge CLK);
    #1 bus.START = 1'b0;
  endtask

  // Offers n elements base, base+1, ...; toggle gates VALID on alternate cycles; restart_at re-pulses START 9x9.
  task automatic feed(input int n, input logic [W-1:0] base, input bit toggle, input int restart_at);
    int  sent = 0;
    int  cyc  = 0;
    bit  v, rdy;
    while (sent < n && cyc < 200) begin
      @(negedge CLK); #1;
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.DATA_IN_VALID = v;
      bus.DATA_IN       = base + W'(sent);
      if (cyc == restart_at) begin
        bus.START = 1'b1; bus.SIZE_I_IN = 9; bus.SIZE_J_IN = 9;
      end else begin
        bus.START = 1'b0;
      end
      rdy = bus.DATA_IN_READY;
      @(posedge CLK);
      if (v && rdy) sent++;
      cyc++;
    end
    @(negedge CLK); #1;
    bus.DATA_IN_VALID = 1'b0;
    bus.START         = 1'b0;
    check("feed_done", W'(sent), W'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    bus.START = 0; bus.SIZE_I_IN = 0; bus.SIZE_J_IN = 0;
    bus.DATA_IN = 0; bus.DATA_IN_VALID = 0;
    RST = 1'b1;
    #1 RST = 1'b0;
    #2;
    check("rst_data_out", bus.DATA_OUT, 0);
    check("rst_ready", W'(bus.READY), 0);
    check("rst_in_ready", W'(bus.DATA_IN_READY), 0);
    idle(3);
    #1 RST = 1'b1;

    // 2x3, VALID held high, data 10..15.
    clear_log();
    pulse_start(2, 3, 1);
    feed(6, 10, 1'b0, -1);
    idle(3);
    check("r1_count", W'(log_q.size()), 6);
    check("r1_ready_pulses", W'(rdy_cnt), 1);
    if (log_q.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        check("r1_data", log_q[k].d, W'(10 + k));
        check("r1_i", log_q[k].i, (k < 3) ? 0 : 1);
        check("r1_j", log_q[k].j, W'(k % 3));
        check("r1_ien", W'(log_q[k].ien), (k == 0 || k == 3) ? 1 : 0);
        check("r1_rdy", W'(log_q[k].rdy), (k == 5) ? 1 : 0);
        check("r1_consecutive", W'(log_q[k].cyc - log_q[0].cyc), W'(k));
      end
    end

    // 2x2, VALID toggling: strobes on alternate cycles.
    clear_log();
    pulse_start(2, 2, 1);
    feed(4, 20, 1'b1, -1);
    idle(3);
    check("r2_count", W'(log_q.size()), 4);
    if (log_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("r2_data", log_q[k].d, W'(20 + k));
        check("r2_gap", W'(log_q[k].cyc - log_q[0].cyc), W'(2 * k));
      end
      check("r2_last_rdy", W'(log_q[3].rdy), 1);
      check("r2_last_idx", {log_q[3].i[31:0], log_q[3].j[31:0]}, {32'd1, 32'd1});
    end

    // Zero size, START held two cycles: the second START lands in the READY cycle and is honoured.
    clear_log();
    pulse_start(0, 5, 2);
    idle(3);
    check("r3_no_strobes", W'(log_q.size()), 0);
    check("r3_ready_pulses", W'(rdy_cnt), 2);

    // 3x3 abandoned by reset after four transfers, then a fresh 1x1.
    clear_log();
    pulse_start(3, 3, 1);
    feed(4, 30, 1'b0, -1);
    #2 RST = 1'b0;
    #1;
    check("r4_rst_data", bus.DATA_OUT, 0);
    check("r4_rst_idx_i", bus.INDEX_I_OUT, 0);
    check("r4_rst_idx_j", bus.INDEX_J_OUT, 0);
    check("r4_rst_in_ready", W'(bus.DATA_IN_READY), 0);
    check("r4_rst_strobe", W'(bus.DATA_OUT_J_ENABLE | bus.DATA_OUT_I_ENABLE | bus.READY), 0);
    idle(2);
    #1 RST = 1'b1;
    check("r4_no_ready", W'(rdy_cnt), 0);
    clear_log();
    pulse_start(1, 1, 1);
    feed(1, 7, 1'b0, -1);
    idle(3);
    check("r4_count", W'(log_q.size()), 1);
    if (log_q.size() == 1) begin
      check("r4_data", log_q[0].d, 7);
      check("r4_idx", log_q[0].i | log_q[0].j, 0);
      check("r4_ien_rdy", W'({log_q[0].ien, log_q[0].rdy}), 3);
    end

    // 1x4 with a 9x9 START mid-stream that must be ignored.
    clear_log();
    pulse_start(1, 4, 1);
    feed(4, 40, 1'b0, 1);
    idle(4);
    check("r5_count", W'(log_q.size()), 4);
    check("r5_ready_pulses", W'(rdy_cnt), 1);
    check("r5_in_ready_after", W'(bus.DATA_IN_READY), 0);
    if (log_q.size() == 4)
      for (int k = 0; k < 4; k++) begin
        check("r5_i", log_q[k].i, 0);
        check("r5_j", log_q[k].j, W'(k));
      end
    bus.SIZE_I_IN = 0; bus.SIZE_J_IN = 0;

`ifdef ACCELERATOR_STATE_FEEDER_COUNT_EN
    // 3x2 element counter steps 1..6 and holds the total.
    clear_log();
    pulse_start(3, 2, 1);
    feed(6, 50, 1'b0, -1);
    idle(3);
    check("r6_count_final", bus.ELEMENT_COUNT_OUT, 6);
    check("r6_ready_pulses", W'(rdy_cnt), 1);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
